// File: rtl/bus_map_pkg.sv
// Shared definitions for the memory-map controller: FSM encoding, the default
// ROM/RAM/UART address map and the error-counter width.
package bus_map_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [31:0] ROM_BASE  = 32'h0040_0000;
    localparam logic [31:0] ROM_MASK  = 32'hFFFF_FF00;
    localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
    localparam logic [31:0] RAM_MASK  = 32'hFFFF_FF00;
    localparam logic [31:0] UART_BASE = 32'h1001_0100;
    localparam logic [31:0] UART_MASK = 32'hFFFF_FFF0;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask decoder: reports a hit, a one-hot select and the
// slave-relative offset. The lowest-numbered matching slave wins.
module bus_addr_decoder
    import bus_map_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int N_SLAVES   = 3
) (
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    input  logic [N_SLAVES*ADDR_WIDTH-1:0] i_base,
    input  logic [N_SLAVES*ADDR_WIDTH-1:0] i_mask,
    output logic                           o_hit,
    output logic [N_SLAVES-1:0]            o_sel,
    output logic [ADDR_WIDTH-1:0]          o_offset
);

    always_comb begin
        o_hit    = 1'b0;
        o_sel    = '0;
        o_offset = '0;
        // Scan high to low so the lowest matching index overrides the rest.
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((i_addr & i_mask[k*ADDR_WIDTH +: ADDR_WIDTH]) == i_base[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                o_hit    = 1'b1;
                o_sel    = '0;
                o_sel[k] = 1'b1;
                o_offset = i_addr & ~i_mask[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

endmodule

// File: rtl/bus_map_ctrl.sv
// Handshaked memory-map controller: decodes the master address onto N slaves,
// waits on slave ready, and answers unmapped/timed-out accesses with a bus error.
module bus_map_ctrl
    import bus_map_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int N_SLAVES   = 3,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {UART_BASE, RAM_BASE, ROM_BASE},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {UART_MASK, RAM_MASK, ROM_MASK},
    parameter int TIMEOUT    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_req,
    input  logic                           m_we,
    input  logic [ADDR_WIDTH-1:0]          m_addr,
    input  logic [DATA_WIDTH-1:0]          m_wdata,
    output logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic                           m_err,
    output logic [N_SLAVES-1:0]            s_sel,
    output logic                           s_we,
    output logic [ADDR_WIDTH-1:0]          s_addr,
    output logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]            s_ready,
    output logic [ERR_CNT_W-1:0]           err_count
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t                  r_state,     w_state_nxt;
    logic [WAIT_W-1:0]       r_wait,      w_wait_nxt;
    logic                    r_we,        w_we_nxt;
    logic                    r_m_ready,   w_m_ready_nxt;
    logic [DATA_WIDTH-1:0]   r_m_rdata,   w_m_rdata_nxt;
    logic                    r_m_err,     w_m_err_nxt;
    logic [N_SLAVES-1:0]     r_s_sel,     w_s_sel_nxt;
    logic                    r_s_we,      w_s_we_nxt;
    logic [ADDR_WIDTH-1:0]   r_s_addr,    w_s_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_s_wdata,   w_s_wdata_nxt;
    logic [ERR_CNT_W-1:0]    r_err_count, w_err_count_nxt;

    logic                    w_dec_hit;
    logic [N_SLAVES-1:0]     w_dec_sel;
    logic [ADDR_WIDTH-1:0]   w_dec_offset;
    logic                    w_slv_ready;
    logic [DATA_WIDTH-1:0]   w_slv_rdata;

    bus_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_SLAVES   (N_SLAVES)
    ) u_dec (
        .i_addr   (m_addr),
        .i_base   (SLAVE_BASE),
        .i_mask   (SLAVE_MASK),
        .o_hit    (w_dec_hit),
        .o_sel    (w_dec_sel),
        .o_offset (w_dec_offset)
    );

    // Only the currently selected slave's ready and data are observed.
    always_comb begin
        w_slv_ready = 1'b0;
        w_slv_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (r_s_sel[k]) begin
                w_slv_ready = w_slv_ready | s_ready[k];
                w_slv_rdata = w_slv_rdata | s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait;
        w_we_nxt        = r_we;
        w_m_ready_nxt   = 1'b0;
        w_m_rdata_nxt   = r_m_rdata;
        w_m_err_nxt     = r_m_err;
        w_s_sel_nxt     = '0;
        w_s_we_nxt      = 1'b0;
        w_s_addr_nxt    = r_s_addr;
        w_s_wdata_nxt   = r_s_wdata;
        w_err_count_nxt = r_err_count;
        case (r_state)
            IDLE: begin
                if (m_req) begin
                    w_we_nxt      = m_we;
                    w_s_wdata_nxt = m_wdata;
                    if (w_dec_hit) begin
                        w_state_nxt  = ACCESS;
                        w_wait_nxt   = '0;
                        w_s_sel_nxt  = w_dec_sel;
                        w_s_we_nxt   = m_we;
                        w_s_addr_nxt = w_dec_offset;
                    end else begin
                        w_state_nxt  = ERR;
                    end
                end
            end
            ACCESS: begin
                // Ready is tested first so it wins over a same-cycle timeout.
                if (w_slv_ready) begin
                    w_state_nxt   = RESP;
                    w_m_rdata_nxt = w_slv_rdata;
                    w_m_err_nxt   = 1'b0;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt   = RESP;
                    w_m_rdata_nxt = '0;
                    w_m_err_nxt   = 1'b1;
                end else begin
                    w_wait_nxt    = r_wait + 1'b1;
                    w_s_sel_nxt   = r_s_sel;
                    w_s_we_nxt    = r_we;
                end
            end
            ERR: begin
                w_state_nxt   = RESP;
                w_m_rdata_nxt = '0;
                w_m_err_nxt   = 1'b1;
            end
            RESP: begin
                w_state_nxt   = IDLE;
                w_m_ready_nxt = 1'b1;
                if (r_m_err && (r_err_count != {ERR_CNT_W{1'b1}}))
                    w_err_count_nxt = r_err_count + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            r_we        <= 1'b0;
            r_m_ready   <= 1'b0;
            r_m_rdata   <= '0;
            r_m_err     <= 1'b0;
            r_s_sel     <= '0;
            r_s_we      <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait      <= w_wait_nxt;
            r_we        <= w_we_nxt;
            r_m_ready   <= w_m_ready_nxt;
            r_m_rdata   <= w_m_rdata_nxt;
            r_m_err     <= w_m_err_nxt;
            r_s_sel     <= w_s_sel_nxt;
            r_s_we      <= w_s_we_nxt;
            r_s_addr    <= w_s_addr_nxt;
            r_s_wdata   <= w_s_wdata_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign m_ready   = r_m_ready;
    assign m_rdata   = r_m_rdata;
    assign m_err     = r_m_err;
    assign s_sel     = r_s_sel;
    assign s_we      = r_s_we;
    assign s_addr    = r_s_addr;
    assign s_wdata   = r_s_wdata;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_bus_map_ctrl.sv
// Directed bench for bus_map_ctrl: a transaction-level timeline model fills
// per-cycle expectations, a compare process checks them every cycle.
module tb_bus_map_ctrl;

    localparam int MAXC = 1024;
    localparam int TO   = 16;

    logic        clk, rst, m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata;
    logic        m_ready, m_err, s_we;
    logic [2:0]  s_sel, s_ready;
    logic [95:0] s_rdata;
    logic [15:0] err_count;

    bus_map_ctrl dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .err_count(err_count)
    );

    logic [31:0] BASES [0:2] = '{32'h0040_0000, 32'h1001_0000, 32'h1001_0100};
    logic [31:0] MASKS [0:2] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FFF0};
    logic [31:0] SDATA [0:2] = '{32'hC0DE_0001, 32'hDEAD_BEEF, 32'h0000_0055};

    logic [2:0]  exp_sel   [0:MAXC-1];
    logic        exp_we    [0:MAXC-1];
    logic [31:0] exp_addr  [0:MAXC-1];
    logic [31:0] exp_wd    [0:MAXC-1];
    logic        exp_ready [0:MAXC-1];
    logic [31:0] exp_rdata [0:MAXC-1];
    logic        exp_err   [0:MAXC-1];
    logic [15:0] exp_cnt   [0:MAXC-1];

    int cyc = 0;
    int n_chk = 0, n_pass = 0;
    int model_cnt = 0;
    int rdy_cyc = 1 << 30;
    logic [2:0] tgt = 3'b000;
    bit chk_en = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Slave stand-in: other slaves' ready is held high as noise; the target
    // raises ready from its scheduled cycle onward.
    initial begin
        s_ready = 3'b000;
        s_rdata = {SDATA[2], SDATA[1], SDATA[0]};
        forever begin
            @(negedge clk);
            #1;
            s_ready = ~tgt | ((cyc >= rdy_cyc) ? tgt : 3'b000);
        end
    end

    // Issue a request at a negedge while the controller idles; it is sampled at
    // the next edge e. d = ready-low ACCESS cycles before the target readies.
    task automatic start_txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                             input int d, output int e);
        int k, n, p;
        bit hit, err;
        logic [31:0] rd;
        m_req = 1; m_we = we; m_addr = addr; m_wdata = wd;
        e = cyc + 1;
        hit = 0; k = 0;
        for (int i = 2; i >= 0; i--)
            if ((addr & MASKS[i]) == BASES[i]) begin hit = 1; k = i; end
        if (hit) begin
            n   = (d + 1 < TO) ? d + 1 : TO;
            err = (d >= TO);
            rd  = err ? 32'h0 : SDATA[k];
            for (int c = e; c < e + n; c++) begin
                exp_sel[c]  = 3'(1 << k);
                exp_we[c]   = we;
                exp_addr[c] = addr & ~MASKS[k];
                exp_wd[c]   = wd;
            end
            tgt = 3'(1 << k);
            rdy_cyc = e + d;
        end else begin
            n = 1; err = 1; rd = 32'h0;
            tgt = 3'b000;
            rdy_cyc = 1 << 30;
        end
        p = e + n + 1;
        exp_ready[p] = 1; exp_rdata[p] = rd; exp_err[p] = err;
        if (err && model_cnt < 16'hFFFF) begin
            model_cnt++;
            for (int c = p; c < MAXC; c++) exp_cnt[c] = 16'(model_cnt);
        end
    endtask

    task automatic wait_ready(input int limit, output int at, output int nsel);
        at = -1; nsel = 0;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge clk);
            if (s_sel != 3'b000) nsel++;
            if (m_ready) at = cyc;
        end
        if (at < 0) begin
            n_chk++;
            $display("FAIL ready_timeout: no m_ready within %0d cycles", limit);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && cyc < MAXC) begin
                chk("s_sel", 32'(s_sel), 32'(exp_sel[cyc]));
                chk("m_ready", 32'(m_ready), 32'(exp_ready[cyc]));
                chk("err_count", 32'(err_count), 32'(exp_cnt[cyc]));
                if (exp_ready[cyc]) begin
                    chk("m_rdata", m_rdata, exp_rdata[cyc]);
                    chk("m_err", 32'(m_err), 32'(exp_err[cyc]));
                end
                if (exp_sel[cyc] != 3'b000) begin
                    chk("s_we", 32'(s_we), 32'(exp_we[cyc]));
                    chk("s_addr", s_addr, exp_addr[cyc]);
                    chk("s_wdata", s_wdata, exp_wd[cyc]);
                end else begin
                    chk("s_we_idle", 32'(s_we), 32'h0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, at, at1, ns;
        rst = 1; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        for (int c = 0; c < MAXC; c++) begin
            exp_sel[c] = 0; exp_we[c] = 0; exp_addr[c] = 0; exp_wd[c] = 0;
            exp_ready[c] = 0; exp_rdata[c] = 0; exp_err[c] = 0; exp_cnt[c] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_m_err", 32'(m_err), 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_s_sel", 32'(s_sel), 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        rst = 0;
        chk_en = 1;
        @(negedge clk);

        // Zero-wait RAM read
        start_txn(32'h1001_0004, 1'b0, 32'h0, 0, e);
        @(negedge clk); m_req = 0;
        chk("t1_sel", 32'(s_sel), 32'h2);
        chk("t1_addr", s_addr, 32'h4);
        wait_ready(40, at, ns);
        chk("t1_lat", at - e, 2);
        chk("t1_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("t1_err", 32'(m_err), 32'h0);
        repeat (2) @(negedge clk);

        // UART write with three wait states
        start_txn(32'h1001_0108, 1'b1, 32'h0000_0041, 3, e);
        @(negedge clk); m_req = 0; m_addr = 32'hFFFF_FFFF; m_wdata = 32'h0;
        chk("t2_we", 32'(s_we), 32'h1);
        chk("t2_wdata", s_wdata, 32'h41);
        chk("t2_addr", s_addr, 32'h8);
        wait_ready(40, at, ns);
        chk("t2_lat", at - e, 5);
        chk("t2_cnt", 32'(err_count), 32'h0);
        repeat (2) @(negedge clk);

        // Unmapped read
        start_txn(32'h2000_0000, 1'b0, 32'h0, 0, e);
        @(negedge clk); m_req = 0;
        wait_ready(40, at, ns);
        chk("t3_lat", at - e, 2);
        chk("t3_nsel", ns, 0);
        chk("t3_err", 32'(m_err), 32'h1);
        chk("t3_rdata", m_rdata, 32'h0);
        chk("t3_cnt", 32'(err_count), 32'h1);
        @(negedge clk);

        // ROM timeout, then ready in the last allowed cycle
        start_txn(32'h0040_0010, 1'b0, 32'h0, 100, e);
        @(negedge clk); m_req = 0;
        ns = 1;
        wait_ready(40, at, at1);
        chk("t4_nsel", ns + at1, 16);
        chk("t4_lat", at - e, 17);
        chk("t4_err", 32'(m_err), 32'h1);
        chk("t4_cnt", 32'(err_count), 32'h2);
        @(negedge clk);
        start_txn(32'h0040_0010, 1'b0, 32'h0, 15, e);
        @(negedge clk); m_req = 0;
        wait_ready(40, at, ns);
        chk("t5_lat", at - e, 17);
        chk("t5_err", 32'(m_err), 32'h0);
        chk("t5_rdata", m_rdata, 32'hC0DE_0001);
        chk("t5_cnt", 32'(err_count), 32'h2);
        @(negedge clk);

        // Back-to-back ROM then RAM with m_req held
        start_txn(32'h0040_0020, 1'b0, 32'h0, 0, e);
        wait_ready(40, at1, ns);
        chk("t6_rdata0", m_rdata, 32'hC0DE_0001);
        start_txn(32'h1001_0010, 1'b0, 32'h0, 0, e);
        wait_ready(40, at, ns);
        m_req = 0;
        chk("t6_gap", at - at1, 3);
        chk("t6_rdata1", m_rdata, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);

        // Reset asserted in the second ACCESS cycle
        start_txn(32'h1001_0020, 1'b0, 32'h0, 5, e);
        while (cyc < e + 1) @(negedge clk);
        rst = 1; m_req = 0;
        model_cnt = 0;
        for (int c = e + 2; c < MAXC; c++) begin
            exp_sel[c] = 0; exp_ready[c] = 0; exp_cnt[c] = 0;
        end
        @(negedge clk);
        rst = 0;
        chk("t7_sel", 32'(s_sel), 32'h0);
        chk("t7_cnt", 32'(err_count), 32'h0);
        at1 = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_ready) at1++;
        end
        chk("t7_no_ready", at1, 0);

        // Normal request after reset
        start_txn(32'h1001_00F0, 1'b1, 32'h1234_5678, 1, e);
        @(negedge clk); m_req = 0;
        wait_ready(40, at, ns);
        chk("t8_lat", at - e, 3);
        chk("t8_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("t8_err", 32'(m_err), 32'h0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_map_ctrl.md
# bus_map_ctrl

Parametrised, handshaked memory-map controller between the multicycle core and N memory-mapped slaves (ROM, RAM, UART, GPIO, …). Replaces fixed three-slave, zero-wait decoding with:
- a per-slave base/mask address map;
- ready-based wait states;
- a bus-error response for unmapped addresses and slave timeouts;
- a saturating error counter.

It sits between the core's address/data mux and the slave bus.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.
- N_SLAVES, 3, number of slave channels (1..8).
- SLAVE_BASE, {32'h1001_0100, 32'h1001_0000, 32'h0040_0000}, packed bases; slave k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_MASK, {32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_FF00}, packed masks, same packing.
- TIMEOUT, 16, maximum ACCESS cycles before a timeout error (≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req  in  1  master request, sampled in IDLE only.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_WIDTH  byte address.
- m_wdata  in  DATA_WIDTH  write data.
- m_ready  out  1  one-cycle completion pulse.
- m_rdata  out  DATA_WIDTH  read data, valid while m_ready = 1.
- m_err  out  1  error flag, valid while m_ready = 1.
- s_sel  out  N_SLAVES  one-hot slave select.
- s_we  out  1  write strobe, qualified by s_sel.
- s_addr  out  ADDR_WIDTH  offset address: m_addr & ~mask of the hit slave.
- s_wdata  out  DATA_WIDTH  write data to slaves.
- s_rdata  in  N_SLAVES*DATA_WIDTH  packed slave read data.
- s_ready  in  N_SLAVES  per-slave completion.
- err_count  out  16  saturating count of error responses.

## Operation
- FSM states are IDLE, ACCESS, ERR and RESP.
- **IDLE.** On m_req=1:
  - latch m_we, m_addr and m_wdata;
  - decode the address: slave k hits when (m_addr & MASK_k) == BASE_k; on multiple hits, the lowest k wins;
  - on a hit, go to ACCESS with the wait counter cleared; on a miss, go to ERR.
- **ACCESS.**
  - Drive s_sel[k]=1, s_we=latched we, s_addr and s_wdata from the latched values.
  - On s_ready[k]=1: capture s_rdata[k] (capture on writes too) and go to RESP with err=0.
  - Otherwise increment the wait counter. If the counter == TIMEOUT-1 and ready is still low, go to RESP with err=1 and rdata=0.
  - s_ready bits of non-selected slaves are ignored.
- **ERR.** One cycle with no slave selected, then go to RESP with err=1 and rdata=0.
- **RESP.**
  - m_ready=1 for exactly one cycle; m_rdata and m_err are held.
  - Return to IDLE. If m_req is still 1 in IDLE, a new transaction starts (back-to-back is allowed).
- m_req, m_addr and the other master inputs are ignored outside IDLE. Master inputs need only be stable at the IDLE sampling edge.
- err_count increments on every RESP with err=1 and saturates at 16'hFFFF.
- s_sel is all-zero in IDLE, ERR and RESP. s_we is 0 whenever s_sel is 0.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE;
  - m_ready, m_err, s_sel, s_we = 0;
  - m_rdata, s_addr, s_wdata = 0;
  - err_count = 0.
- Latency, with the request sampled at edge E0:
  - zero-wait slave (s_ready=1 in the first ACCESS cycle): m_ready is high in the cycle after edge E2, i.e. 2 cycles after the request;
  - each cycle that ready stays low adds 1 cycle;
  - timeout: m_ready arrives TIMEOUT+1 cycles after the request;
  - unmapped address: m_ready arrives 2 cycles after the request.
- If s_ready and the timeout fire in the same (last) ACCESS cycle, ready wins and err=0.
- rst=1 in any state, including mid-ACCESS:
  - return to IDLE next cycle and drop s_sel immediately;
  - the transaction is lost with no m_ready pulse;
  - err_count clears.
- Throughput is at most one transaction per 3 cycles.

## Structure
- Package bus_map_pkg holds:
  - state encodings (IDLE=2'd0, ACCESS=2'd1, ERR=2'd2, RESP=2'd3);
  - the default address-map constants (ROM/RAM/UART bases and masks);
  - the error-counter width (16).
- Sub-module bus_addr_decoder (combinational): takes address and packed base/mask; outputs hit, a one-hot select and the offset address. It is instantiated once in bus_map_ctrl.
- The FSM, wait counter, latch registers and read-data capture mux live in bus_map_ctrl.

## Test plan
- **Zero-wait RAM read.** Read of 0x1001_0004 with s_ready[1] tied to 1 and s_rdata[1]=32'hDEAD_BEEF → s_sel=3'b010, s_addr=0x04; m_ready arrives 2 cycles after the request with m_rdata=32'hDEAD_BEEF and m_err=0.
- **Wait-state UART write.** Write 0x0000_0041 to 0x1001_0108; s_ready[2] rises after 3 ACCESS cycles → s_we=1 with s_wdata=0x41 and s_addr=0x8 throughout ACCESS; m_ready arrives 5 cycles after the request; err_count stays 0.
- **Unmapped address.** Read of 0x2000_0000 → s_sel never asserts; m_ready arrives 2 cycles after the request with m_err=1 and m_rdata=0; err_count becomes 1.
- **Timeout.** TIMEOUT=16 and the ROM never readies, on a read of 0x0040_0010 → s_sel=3'b001 for exactly 16 cycles, then m_ready with m_err=1; err_count increments. A second run raises s_ready in cycle 16 → err=0.
- **Back-to-back.** m_req held high for two reads (ROM, then RAM) → two m_ready pulses 3 cycles apart, with correct data in each.
- **Reset mid-ACCESS.** Assert rst in the second ACCESS cycle → s_sel=0 the next cycle, no m_ready pulse, err_count=0; the next request completes normally.
